// File: rtl/lfsr_bit_packer_pkg.sv
// Shared definitions for the LFSR bit packer slice.
//   FIFO_DEPTH : entries in the output word FIFO
//   RUN_W      : width of the identical-bit run counter (saturates at all-ones)
//   CNT_W      : width of the handed-off word counter
//   run_next() : next value of the run counter for one accepted bit
package lfsr_bit_packer_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int RUN_W      = 8;
    localparam int CNT_W      = 16;

    typedef logic [RUN_W-1:0] run_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam run_t RUN_MAX = '1;

    // A differing bit starts a new run of length 1; an equal bit extends
    // the run, holding at RUN_MAX instead of wrapping back to a short run.
    function automatic run_t run_next(input run_t run, input logic same);
        if (!same)
            return run_t'(1);
        else if (run == RUN_MAX)
            return RUN_MAX;
        else
            return run + run_t'(1);
    endfunction

endpackage

// File: rtl/lfsr_bit_packer_fifo.sv
// Two-entry synchronous FIFO (module sync_fifo2).
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write request and data; accepted when not full, or when
//                full and a pop frees a slot on the same edge
//   pop        : read request; ignored when empty
//   rdata      : head entry, driven from registers only
//   full/empty : occupancy flags derived from the registered count
module sync_fifo2
    import lfsr_bit_packer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'(FIFO_DEPTH));
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    // When full, the write lands in the slot being read out on this edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two storage words are reset because the head word is
            // visible on out_data and must read as zero out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values, regardless of statement order.
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            if (do_push && !do_pop)
                count <= count + 2'd1;
            else if (do_pop && !do_push)
                count <= count - 2'd1;
        end
    end

endmodule

// File: rtl/lfsr_bit_packer.sv
// Packs a qualified serial bit stream MSB-first into W-bit words, hands them
// out through a 2-entry valid/ready FIFO, and flags long runs of identical
// bits (a locked-up LFSR).
//   clk, rst_n : clock, asynchronous active-low reset
//   in, in_en  : serial bit and its qualifier
//   out_data   : head word (first received bit in out_data[W-1])
//   out_valid  : FIFO non-empty
//   out_ready  : consumer accepts the head word on out_valid && out_ready
//   overflow   : sticky, a completed word was dropped on a full FIFO
//   stuck      : current run of identical accepted bits >= STUCK_LEN
//   word_cnt   : count of handed-off words, wrapping
module lfsr_bit_packer
    import lfsr_bit_packer_pkg::*;
#(
    parameter int W         = 8,
    parameter int STUCK_LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             in_en,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             stuck,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int BC_W = $clog2(W);

    logic [W-2:0]  shift_q;   // the W-1 bits received so far of the current word
    logic [BC_W-1:0] bit_cnt;
    logic [W-1:0]  word;
    logic          word_done;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          prev_bit;
    run_t          run_q;
    run_t          run_nxt;

    assign word      = {shift_q, in};
    assign word_done = in_en && (bit_cnt == BC_W'(W - 1));
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    always_comb begin
        // NOTE: default first so every path assigns run_nxt and no latch forms.
        run_nxt = run_q;
        if (in_en)
            run_nxt = run_next(run_q, in == prev_bit);
    end

    sync_fifo2 #(
        .WIDTH (W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (word_done),
        .wdata (word),
        .pop   (pop),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            bit_cnt  <= '0;
            prev_bit <= 1'b0;
            run_q    <= '0;
            stuck    <= 1'b0;
            overflow <= 1'b0;
            word_cnt <= '0;
        end else begin
            if (in_en) begin
                shift_q  <= word[W-2:0];
                bit_cnt  <= word_done ? '0 : bit_cnt + BC_W'(1);
                prev_bit <= in;
                run_q    <= run_nxt;
                stuck    <= (run_nxt >= run_t'(STUCK_LEN));
            end
            // A full FIFO only refuses the word when nothing leaves this edge.
            if (word_done && fifo_full && !pop)
                overflow <= 1'b1;
            if (pop)
                word_cnt <= word_cnt + cnt_t'(1);
        end
    end

endmodule

// File: tb/tb_lfsr_bit_packer.sv
// Self-checking bench for lfsr_bit_packer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// queue-based behavioural model.
module tb_lfsr_bit_packer;

    localparam int W         = 8;
    localparam int STUCK_LEN = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din = 1'b0;
    logic          in_en = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          overflow;
    logic          stuck;
    logic [15:0]   word_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model state
    logic [W-1:0] m_fifo[$];
    bit           m_hist[$];
    int           m_word;
    int           m_nbits;
    bit           m_ovf;
    int           m_wc;

    lfsr_bit_packer #(
        .W         (W),
        .STUCK_LEN (STUCK_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (din),
        .in_en     (in_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .stuck     (stuck),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_fifo.delete();
        m_hist.delete();
        m_word  = 0;
        m_nbits = 0;
        m_ovf   = 1'b0;
        m_wc    = 0;
    endfunction

    // Length of the trailing run of identical accepted bits, capped at 255.
    function automatic int model_run();
        int r = 0;
        int last;
        if (m_hist.size() == 0) return 0;
        last = m_hist.size() - 1;
        for (int i = last; i >= 0; i--) begin
            if (m_hist[i] != m_hist[last]) break;
            r++;
        end
        return (r > 255) ? 255 : r;
    endfunction

    // Model advances on each rising edge from the inputs presented to the DUT.
    always @(posedge clk) begin
        if (rst_n) begin
            if (m_fifo.size() > 0 && out_ready) begin
                void'(m_fifo.pop_front());
                m_wc = (m_wc + 1) % 65536;
            end
            if (in_en) begin
                m_hist.push_back(din);
                if (m_hist.size() > 300) void'(m_hist.pop_front());
                m_word = m_word * 2 + int'(din);
                m_nbits++;
                if (m_nbits == W) begin
                    if (m_fifo.size() < 2) m_fifo.push_back(m_word[W-1:0]);
                    else m_ovf = 1'b1;
                    m_word  = 0;
                    m_nbits = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("valid", out_valid, m_fifo.size() != 0);
            if (m_fifo.size() != 0) check("data", out_data, m_fifo[0]);
            check("overflow", overflow, m_ovf);
            check("stuck", stuck, model_run() >= STUCK_LEN);
            check("word_cnt", word_cnt, m_wc);
        end
    end

    task automatic drive(input logic b, input logic en);
        @(negedge clk);
        din   = b;
        in_en = en;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap);
        for (int i = W - 1; i >= 0; i--) begin
            if (i != W - 1) repeat (gap) idle();
            drive(w[i], 1'b1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        din   = 1'b0;
        in_en = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_stuck"}, stuck, 0);
        check({tag, "_wcnt"}, word_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] t1_bits;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Basic word, MSB-first, popped immediately
        out_ready = 1'b1;
        t1_bits = 8'hB2;
        for (int i = 7; i >= 0; i--) drive(t1_bits[i], 1'b1);
        idle();
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 8'hB2);
        idle();
        check("t1_wcnt", word_cnt, 1);
        check("t1_valid_after_pop", out_valid, 0);

        // Overflow: third word dropped while FIFO full
        do_reset();
        out_ready = 1'b0;
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        send_word(8'hFF, 0);
        idle();
        check("t2_ovf", overflow, 1);
        check("t2_head_a5", out_data, 8'hA5);
        out_ready = 1'b1;
        idle();
        check("t2_head_3c", out_data, 8'h3C);
        idle();
        check("t2_empty", out_valid, 0);
        check("t2_wcnt", word_cnt, 2);
        check("t2_ovf_sticky", overflow, 1);

        // Push and pop on the same edge while full
        do_reset();
        out_ready = 1'b0;
        send_word(8'h11, 0);
        send_word(8'h22, 0);
        for (int i = W - 1; i >= 1; i--) drive(1'(8'h33 >> i), 1'b1);
        drive(1'b1, 1'b1);
        out_ready = 1'b1;
        idle();
        check("t3_no_ovf", overflow, 0);
        check("t3_head_22", out_data, 8'h22);
        idle();
        check("t3_head_33", out_data, 8'h33);
        idle();
        check("t3_empty", out_valid, 0);
        check("t3_wcnt", word_cnt, 3);

        // Run monitor threshold, break and saturation
        do_reset();
        out_ready = 1'b1;
        repeat (7) drive(1'b0, 1'b1);
        idle();
        check("t4_stuck_7", stuck, 0);
        drive(1'b0, 1'b1);
        idle();
        check("t4_stuck_8", stuck, 1);
        drive(1'b1, 1'b1);
        idle();
        check("t4_stuck_break", stuck, 0);
        repeat (300) drive(1'b0, 1'b1);
        idle();
        check("t4_stuck_sat", stuck, 1);

        // Asynchronous reset mid-word
        do_reset();
        out_ready = 1'b0;
        send_word(8'h00, 0);
        repeat (5) drive(1'b0, 1'b1);
        idle();
        check("t5_pre_valid", out_valid, 1);
        check("t5_pre_stuck", stuck, 1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("t5_async");
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send_word(8'h81, 0);
        idle();
        check("t5_valid", out_valid, 1);
        check("t5_data", out_data, 8'h81);
        idle();
        check("t5_wcnt", word_cnt, 1);

        // Gapped input
        do_reset();
        out_ready = 1'b1;
        send_word(8'h5A, 1);
        idle();
        check("t6_data", out_data, 8'h5A);
        send_word(8'hFF, 1);
        idle();
        check("t6_stuck_gaps", stuck, 1);

        // Randomized traffic in three flavours
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c < 1000) begin
                din       = 1'($urandom_range(0, 1));
                in_en     = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
            end else if (c < 2000) begin
                din       = 1'($urandom_range(0, 1));
                in_en     = 1'b1;
                out_ready = ($urandom_range(0, 15) == 0);
            end else begin
                din       = ($urandom_range(0, 19) == 0);
                in_en     = ($urandom_range(0, 4) != 0);
                out_ready = ($urandom_range(0, 1) != 0);
            end
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
